// File: rtl/round_stage_pipe.sv
// round_stage_pipe: two-stage FP rounding and packing pipeline with valid/ready flow control.
// S1 computes the rounding increment and the rounded significand. S2 rebiases the exponent,
// resolves zero, denormal and overflow cases, and registers the packed result.
// Optional build macro ROUND_FLAGS_EN adds the flags[3:0] = {ovf, unf, inx, zero} output.
module round_stage_pipe #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned FRAC_W   = 23,
  parameter int unsigned EXP_IN_W = 10,
  parameter int unsigned BIAS     = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  nj_mode,
  input  logic [1:0]            rnd_mode,
  input  logic                  s_final,
  input  logic [EXP_IN_W-1:0]   exp_norm,
  input  logic [FRAC_W+3:0]     frac_norm,
  input  logic                  denorm_m,
  input  logic                  zero_m,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] res
`ifdef ROUND_FLAGS_EN
  ,
  output logic [3:0]            flags
`endif
);

  localparam int unsigned RES_W   = 1 + EXP_W + FRAC_W;
  localparam int unsigned SUM_W   = FRAC_W + 2;
  localparam int unsigned EI_W    = EXP_IN_W + 1;
  localparam int unsigned EXP_MAX = (32'd1 << EXP_W) - 32'd1;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam logic signed [EI_W-1:0] EXP_MAX_S = EI_W'(EXP_MAX);

  // Pipeline control
  logic s1_adv_c, s2_adv_c, accept_c;

  // Stage 1 registers
  logic                s1_v_q;
  logic                s1_sign_q;
  logic [EXP_IN_W-1:0] s1_exp_q;
  logic [SUM_W-1:0]    s1_sum_q;
  logic [1:0]          s1_mode_q;
  logic                s1_nj_q;
  logic                s1_denorm_q;
  logic                s1_zero_q;

  // Stage 2 registers
  logic                s2_v_q;
  logic [RES_W-1:0]    res_q;

  // Stage 1 next-state
  logic [FRAC_W:0]     z1_c;
  logic [2:0]          grs_c;
  logic                inc_c;
  logic [SUM_W-1:0]    sum_d;

  // Stage 2 next-state
  logic signed [EI_W-1:0] e_c;
  logic                   ovf_path_c;
  logic                   to_inf_c;
  logic [RES_W-1:0]       res_d;

  // Handshake: S2 drains when empty or popped, S1 moves when S2 moves or S1 is empty
  always_comb begin
    s2_adv_c = !s2_v_q || out_ready;
    s1_adv_c = s2_adv_c || !s1_v_q;
    in_ready = s1_adv_c;
    accept_c = in_valid && s1_adv_c;
  end

  // Rounding increment per mode and the rounded significand with carry-out
  always_comb begin
    z1_c  = frac_norm[FRAC_W+3:3];
    grs_c = frac_norm[2:0];
    inc_c = 1'b0;
    case (rnd_mode)
      RM_RNE: inc_c = grs_c[2] && (grs_c[1] || grs_c[0] || z1_c[0]);
      RM_RTZ: inc_c = 1'b0;
      RM_RUP: inc_c = !s_final && (|grs_c);
      RM_RDN: inc_c = s_final && (|grs_c);
    endcase
    sum_d = SUM_W'(z1_c) + SUM_W'(inc_c);
  end

  // Exponent rebias and result selection (zero > denormal > overflow > normal)
  always_comb begin
    e_c = $signed({s1_exp_q[EXP_IN_W-1], s1_exp_q}) + $signed(EI_W'(BIAS))
        + $signed(EI_W'(s1_sum_q[SUM_W-1]));
    to_inf_c   = (s1_mode_q == RM_RNE) || ((s1_mode_q == RM_RUP) && !s1_sign_q)
              || ((s1_mode_q == RM_RDN) && s1_sign_q);
    ovf_path_c = 1'b0;
    res_d      = '0;
    if (s1_zero_q) begin
      res_d = '0;
    end else if (s1_denorm_q) begin
      if (s1_nj_q) begin
        res_d = {s1_sign_q, {(RES_W-1){1'b0}}};
      end else begin
        // A carry into the hidden position promotes the value to the smallest normal
        res_d = {s1_sign_q, EXP_W'(s1_sum_q[FRAC_W]), s1_sum_q[FRAC_W-1:0]};
      end
    end else if (e_c >= EXP_MAX_S) begin
      ovf_path_c = 1'b1;
      if (to_inf_c) begin
        res_d = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else begin
        res_d = {s1_sign_q, EXP_W'(EXP_MAX - 32'd1), {FRAC_W{1'b1}}};
      end
    end else begin
      // On significand carry-out the low fraction bits are already zero
      res_d = {s1_sign_q, e_c[EXP_W-1:0], s1_sum_q[FRAC_W-1:0]};
    end
  end

  // Stage 1 register: valid follows the slot, payload loads only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_sum_q    <= '0;
      s1_mode_q   <= '0;
      s1_nj_q     <= 1'b0;
      s1_denorm_q <= 1'b0;
      s1_zero_q   <= 1'b0;
    end else begin
      if (s1_adv_c) begin
        s1_v_q <= in_valid;
      end
      if (accept_c) begin
        s1_sign_q   <= s_final;
        s1_exp_q    <= exp_norm;
        s1_sum_q    <= sum_d;
        s1_mode_q   <= rnd_mode;
        s1_nj_q     <= nj_mode;
        s1_denorm_q <= denorm_m;
        s1_zero_q   <= zero_m;
      end
    end
  end

  // Stage 2 register: packed result held stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      res_q  <= '0;
    end else begin
      if (s2_adv_c) begin
        s2_v_q <= s1_v_q;
      end
      if (s2_adv_c && s1_v_q) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign res       = res_q;

`ifdef ROUND_FLAGS_EN
  logic       s1_inx_q;
  logic [3:0] flags_d;
  logic [3:0] flags_q;

  // Inexact tracked alongside stage 1 payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inx_q <= 1'b0;
    end else if (accept_c) begin
      s1_inx_q <= |frac_norm[2:0];
    end
  end

  // Flag word {ovf, unf, inx, zero} derived from the S2 decision
  always_comb begin
    flags_d    = '0;
    flags_d[3] = ovf_path_c;
    flags_d[2] = s1_denorm_q && s1_inx_q;
    flags_d[1] = s1_inx_q || ovf_path_c;
    flags_d[0] = (res_d[RES_W-2:0] == '0);
  end

  // Flags registered together with res
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (s2_adv_c && s1_v_q) begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_round_stage_pipe.sv
// Testbench for round_stage_pipe (default single-precision parameters).
module tb_round_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        nj_mode;
  logic [1:0]  rnd_mode;
  logic        s_final;
  logic [9:0]  exp_norm;
  logic [26:0] frac_norm;
  logic        denorm_m;
  logic        zero_m;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
`ifdef ROUND_FLAGS_EN
  logic [3:0]  flags;
`endif

  round_stage_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .nj_mode   (nj_mode),
    .rnd_mode  (rnd_mode),
    .s_final   (s_final),
    .exp_norm  (exp_norm),
    .frac_norm (frac_norm),
    .denorm_m  (denorm_m),
    .zero_m    (zero_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
`ifdef ROUND_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [35:0] exp_q[$];
  bit          hold_pend = 0;
  logic [31:0] held_res;
  int          cur_ex;
  int unsigned stalls = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  // Reference: integer rounding of the 24-bit significand, then IEEE packing
  function automatic logic [35:0] ref_model(input logic s, input logic [1:0] rm, input logic nj,
                                            input int ex, input logic [26:0] fr,
                                            input logic den, input logic z);
    int unsigned mant, grs, m;
    int          e;
    bit          inc, inx, ovf, to_inf;
    logic [31:0] r;
    logic [31:0] sbit;
    logic [3:0]  f;
    mant = 32'(fr) >> 3;
    grs  = 32'(fr) & 32'd7;
    inx  = (grs != 0);
    case (rm)
      2'd0:    inc = (grs > 4) || (grs == 4 && (mant % 2 == 1));
      2'd1:    inc = 0;
      2'd2:    inc = !s && inx;
      default: inc = s && inx;
    endcase
    m    = mant + (inc ? 1 : 0);
    e    = ex + 127 + ((m >= 32'h0100_0000) ? 1 : 0);
    sbit = s ? 32'h8000_0000 : 32'h0;
    ovf  = 0;
    to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
    if (z)                r = 32'h0;
    else if (den && nj)   r = sbit;
    else if (den)         r = sbit | m;
    else if (e >= 255) begin
      ovf = 1;
      r   = sbit | (to_inf ? 32'h7F80_0000 : 32'h7F7F_FFFF);
    end else              r = sbit | (32'(e) << 23) | (m & 32'h007F_FFFF);
    f = {ovf, den && inx, inx || ovf, (r[30:0] == 31'h0)};
    return {f, r};
  endfunction

  task automatic set_beat(input logic s, input logic [1:0] rm, input logic nj, input int ex,
                          input logic [26:0] fr, input logic den, input logic z);
    s_final = s; rnd_mode = rm; nj_mode = nj; cur_ex = ex; exp_norm = 10'(ex);
    frac_norm = fr; denorm_m = den; zero_m = z;
  endtask

  task automatic rand_beat();
    logic        den, z;
    logic [26:0] fr;
    int          ex;
    den = ($urandom % 8 == 0);
    z   = ($urandom % 16 == 0);
    fr  = 27'($urandom);
    if ($urandom % 4 == 0) fr[25:3] = '1;
    fr[26] = !den;
    ex  = den ? -126 : (int'($urandom_range(0, 255)) - 126);
    set_beat(1'($urandom), 2'($urandom), 1'($urandom), ex, fr, den, z);
  endtask

  task automatic compare_out(input string tag, input logic [35:0] want);
    check(tag, 64'(res), 64'(want[31:0]));
`ifdef ROUND_FLAGS_EN
    check({tag, "_flags"}, 64'(flags), 64'(want[35:32]));
`endif
  endtask

  // One directed beat into an empty pipe, result compared with a fixed constant
  task automatic run_vec(input string tag, input logic s, input logic [1:0] rm, input logic nj,
                         input int ex, input logic [26:0] fr, input logic den, input logic z,
                         input logic [31:0] want);
    logic [35:0] m;
    int          n;
    @(negedge clk);
    set_beat(s, rm, nj, ex, fr, den, z);
    in_valid = 1'b1; out_ready = 1'b1;
    m = ref_model(s, rm, nj, ex, fr, den, z);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin @(negedge clk); n++; end
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    compare_out(tag, {m[35:32], want});
    @(negedge clk);
  endtask

  // One cycle of traffic. mode 0: random, 1: full-rate burst, 2: drain
  task automatic step(input int mode);
    logic [35:0] w;
    @(negedge clk);
    in_valid  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom % 4 != 0);
    out_ready = (mode != 0) ? 1'b1 : ($urandom % 3 != 0);
    rand_beat();
    #1;
    if (hold_pend) begin
      check("hold_vld", 64'(out_valid), 64'd1);
      check("hold_res", 64'(res), 64'(held_res));
    end
    hold_pend = out_valid && !out_ready;
    held_res  = res;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("q_nonempty", 64'(exp_q.size()), 64'd1);
      else begin
        w = exp_q.pop_front();
        compare_out("stream", w);
      end
    end
    if (mode == 1 && !in_ready) stalls++;
    if (in_valid && in_ready)
      exp_q.push_back(ref_model(s_final, rnd_mode, nj_mode, cur_ex, frac_norm, denorm_m, zero_m));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_beat(0, 0, 0, 0, 27'h0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec("rne_tie_even", 0, 2'd0, 0, 0, {1'b1, 23'h0, 3'b100}, 0, 0, 32'h3F80_0000);
    run_vec("rne_tie_odd",  0, 2'd0, 0, 0, {1'b1, 23'h1, 3'b100}, 0, 0, 32'h3F80_0002);
    run_vec("sweep_rne",    1, 2'd0, 0, 0, {1'b1, 23'h0, 3'b010}, 0, 0, 32'hBF80_0000);
    run_vec("sweep_rtz",    1, 2'd1, 0, 0, {1'b1, 23'h0, 3'b010}, 0, 0, 32'hBF80_0000);
    run_vec("sweep_rup",    1, 2'd2, 0, 0, {1'b1, 23'h0, 3'b010}, 0, 0, 32'hBF80_0000);
    run_vec("sweep_rdn",    1, 2'd3, 0, 0, {1'b1, 23'h0, 3'b010}, 0, 0, 32'hBF80_0001);
    run_vec("carry",        0, 2'd0, 0, 0,   {1'b1, 23'h7FFFFF, 3'b110}, 0, 0, 32'h4000_0000);
    run_vec("ovf_rne_inf",  0, 2'd0, 0, 127, {1'b1, 23'h7FFFFF, 3'b110}, 0, 0, 32'h7F80_0000);
    run_vec("ovf_rtz_max",  0, 2'd1, 0, 127, {1'b1, 23'h7FFFFF, 3'b110}, 0, 0, 32'h7F7F_FFFF);
    run_vec("ovf_rdn_neg",  1, 2'd3, 0, 127, {1'b1, 23'h7FFFFF, 3'b110}, 0, 0, 32'hFF80_0000);
    run_vec("den_flush",    1, 2'd0, 1, -126, {1'b0, 23'h123456, 3'b011}, 1, 0, 32'h8000_0000);
    run_vec("den_promote",  0, 2'd0, 0, -126, {1'b0, 23'h7FFFFF, 3'b100}, 1, 0, 32'h0080_0000);
    run_vec("zero_neg",     1, 2'd0, 0, 5,    {1'b1, 23'h0, 3'b000}, 0, 1, 32'h0000_0000);

    repeat (150) step(0);
    stalls = 0;
    repeat (25) step(1);
    check("burst_stalls", 64'(stalls), 64'd0);
    repeat (40) step(0);

    // Reset with beats in flight: everything is discarded
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_res", 64'(res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    hold_pend = 0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_idle", 64'(out_valid), 64'd0);

    repeat (150) step(0);
    repeat (6) step(2);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
